// File: rtl/latch_input_conditioner.sv
// Synchronises and debounces raw data/strobe switch lines, then drives a latch
// with a setup / enable-pulse / hold sequence so data is stable while enabled.
module latch_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_data,
  input  logic       raw_strobe,
  output logic       input1,
  output logic       input2,
  output logic       busy,
  output logic [7:0] glitch_count
);

  // state | meaning
  // IDLE  | input1 tracks debounced data, waiting for a strobe rise
  // SETUP | data captured and frozen, enable still low
  // PULSE | enable high for PULSE_CYCLES cycles
  // HOLD  | enable low again, data held one more cycle
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  // Line index 0 is data, 1 is strobe.
  logic [1:0]             raw_line;
  logic [SYNC_STAGES-1:0] sync_q   [2];
  logic [1:0]             deb_q;
  logic [1:0]             deb_next;
  logic [CNT_W-1:0]       deb_cnt_q    [2];
  logic [CNT_W-1:0]       deb_cnt_next [2];
  logic [1:0]             glitch_hit;
  logic [8:0]             glitch_sum;
  logic [7:0]             glitch_q;
  logic [7:0]             glitch_next;
  logic                   strobe_prev_q;
  logic                   strobe_rise;

  state_t                 state_q;
  state_t                 state_next;
  logic [CNT_W-1:0]       pulse_cnt_q;
  logic [CNT_W-1:0]       pulse_cnt_next;
  logic                   input1_q;
  logic                   input1_next;
  logic                   input2_q;
  logic                   input2_next;
  logic                   busy_q;
  logic                   busy_next;

  assign raw_line = {raw_strobe, raw_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]    <= '0;
        deb_cnt_q[i] <= '0;
      end
      deb_q         <= '0;
      glitch_q      <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]    <= {sync_q[i][SYNC_STAGES-2:0], raw_line[i]};
        deb_cnt_q[i] <= deb_cnt_next[i];
      end
      deb_q         <= deb_next;
      glitch_q      <= glitch_next;
      strobe_prev_q <= deb_q[1];
    end
  end

  // A disagreement run that ends before reaching the threshold is a rejected bounce.
  always_comb begin
    deb_next   = deb_q;
    glitch_hit = '0;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_next[i] = deb_cnt_q[i];
      if (sync_q[i][SYNC_STAGES-1] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_next[i]     = sync_q[i][SYNC_STAGES-1];
          deb_cnt_next[i] = '0;
        end else begin
          deb_cnt_next[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end else begin
        deb_cnt_next[i] = '0;
        glitch_hit[i]   = (deb_cnt_q[i] != '0);
      end
    end
  end

  always_comb begin
    glitch_sum  = {1'b0, glitch_q} + {8'd0, glitch_hit[0]} + {8'd0, glitch_hit[1]};
    glitch_next = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
  end

  assign strobe_rise = deb_q[1] & ~strobe_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      input1_q    <= 1'b0;
      input2_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_next;
      pulse_cnt_q <= pulse_cnt_next;
      input1_q    <= input1_next;
      input2_q    <= input2_next;
      busy_q      <= busy_next;
    end
  end

  // input2 is decoded from the next state so the registered enable never glitches.
  always_comb begin
    state_next     = state_q;
    pulse_cnt_next = pulse_cnt_q;
    input1_next    = input1_q;
    input2_next    = 1'b0;
    case (state_q)
      IDLE: begin
        input1_next = deb_q[0];
        if (strobe_rise) state_next = SETUP;
      end
      SETUP: begin
        state_next     = PULSE;
        pulse_cnt_next = '0;
        input2_next    = 1'b1;
      end
      PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_next = HOLD;
        end else begin
          pulse_cnt_next = pulse_cnt_q + CNT_W'(1);
          input2_next    = 1'b1;
        end
      end
      HOLD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign input1       = input1_q;
  assign input2       = input2_q;
  assign busy         = busy_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Randomised and directed bench for latch_input_conditioner against a
// cycle-level behavioural model of the debounce and write sequence.
module tb_latch_input_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_data;
  logic       raw_strobe;
  logic       input1;
  logic       input2;
  logic       busy;
  logic [7:0] glitch_count;

  int n_compared = 0;
  int n_mismatched = 0;

  latch_input_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_data(raw_data), .raw_strobe(raw_strobe),
    .input1(input1), .input2(input2), .busy(busy), .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: delay line, disagreement streaks, and a write timer
  // counting edges since the write was triggered (-1 when idle).
  bit          m_sync [2][S];
  bit          m_deb  [2];
  int          m_streak [2];
  bit          m_prev_s;
  int          m_t;
  bit          m_in1;
  int          m_glitch;
  logic [10:0] m_out;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < S; j++) m_sync[i][j] = 1'b0;
      m_deb[i] = 1'b0;
      m_streak[i] = 0;
    end
    m_prev_s = 1'b0;
    m_t = -1;
    m_in1 = 1'b0;
    m_glitch = 0;
    m_out = '0;
  endtask

  task automatic model_update(input bit d, input bit s);
    bit rise;
    bit sync_out;
    int hits;
    rise = m_deb[1] && !m_prev_s;
    if (m_t < 0) begin
      m_in1 = m_deb[0];
      if (rise) m_t = 0;
    end else begin
      m_t++;
      if (m_t == P + 2) m_t = -1;
    end
    m_prev_s = m_deb[1];
    hits = 0;
    for (int i = 0; i < 2; i++) begin
      sync_out = m_sync[i][S-1];
      if (sync_out != m_deb[i]) m_streak[i]++;
      else begin
        if (m_streak[i] > 0) hits++;
        m_streak[i] = 0;
      end
      if (m_streak[i] == D) begin
        m_deb[i] = sync_out;
        m_streak[i] = 0;
      end
      for (int j = S - 1; j > 0; j--) m_sync[i][j] = m_sync[i][j-1];
      m_sync[i][0] = (i == 0) ? d : s;
    end
    m_glitch = (m_glitch + hits > 255) ? 255 : m_glitch + hits;
    m_out = {m_in1, (m_t >= 1 && m_t <= P), (m_t >= 0), 8'(m_glitch)};
  endtask

  task automatic tick(input bit d, input bit s);
    raw_data = d;
    raw_strobe = s;
    @(posedge clk);
    model_update(d, s);
    #1;
  endtask

  task automatic settle(input bit d, input bit s, input int n);
    for (int k = 0; k < n; k++) tick(d, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_data = 1'($urandom_range(0, 1));
    raw_strobe = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if ({input1, input2, busy, glitch_count} !== 11'd0) begin
      n_mismatched++;
      $display("FAIL reset_state: got in1=%b in2=%b busy=%b glitch=%0d, want all 0",
               input1, input2, busy, glitch_count);
    end
    raw_data = 1'b0;
    raw_strobe = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clean_data();
    settle(0, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      tick(1, 0);
      n_compared++;
      if ({input1, input2, busy, glitch_count} !== m_out) begin
        n_mismatched++;
        $display("FAIL clean_data_model k=%0d: got %h want %h", k,
                 {input1, input2, busy, glitch_count}, m_out);
      end
      if (k == 6 || k == 7) begin
        n_compared++;
        if (input1 !== (k == 7) || input2 !== 1'b0 || glitch_count !== 8'd0) begin
          n_mismatched++;
          $display("FAIL clean_data_edge k=%0d: got in1=%b in2=%b glitch=%0d, want in1=%0d in2=0 glitch=0",
                   k, input1, input2, glitch_count, (k == 7));
        end
      end
    end
  endtask

  task automatic test_write_cycle();
    bit exp_busy;
    bit exp_in2;
    settle(1, 0, 10);
    for (int k = 1; k <= 14; k++) begin
      tick(1, 1);
      exp_busy = (k >= 7 && k <= 10);
      exp_in2 = (k == 8 || k == 9);
      n_compared++;
      if (busy !== exp_busy || input2 !== exp_in2 || input1 !== 1'b1) begin
        n_mismatched++;
        $display("FAIL write_cycle k=%0d: got busy=%b in2=%b in1=%b, want busy=%b in2=%b in1=1",
                 k, busy, input2, input1, exp_busy, exp_in2);
      end
    end
    settle(1, 0, 12);
  endtask

  task automatic test_bounce();
    settle(0, 0, 12);
    tick(1, 0); tick(1, 0);
    repeat (4) tick(0, 0);
    n_compared++;
    if (input1 !== 1'b0 || glitch_count !== 8'd1) begin
      n_mismatched++;
      $display("FAIL bounce_single: got in1=%b glitch=%0d, want in1=0 glitch=1", input1, glitch_count);
    end
    tick(1, 1); tick(1, 1);
    repeat (4) tick(0, 0);
    n_compared++;
    if (input1 !== 1'b0 || busy !== 1'b0 || glitch_count !== 8'd3) begin
      n_mismatched++;
      $display("FAIL bounce_both_lines: got in1=%b busy=%b glitch=%0d, want in1=0 busy=0 glitch=3",
               input1, busy, glitch_count);
    end
  endtask

  task automatic test_frozen();
    bit exp_in1;
    settle(1, 0, 12);
    for (int k = 1; k <= 20; k++) begin
      tick((k < 8) ? 1'b1 : 1'b0, 1'b1);
      exp_in1 = (k <= 13);
      n_compared++;
      if (input1 !== exp_in1 || input2 !== (k == 8 || k == 9)) begin
        n_mismatched++;
        $display("FAIL data_frozen k=%0d: got in1=%b in2=%b, want in1=%b in2=%0d",
                 k, input1, input2, exp_in1, (k == 8 || k == 9));
      end
    end
    settle(0, 0, 12);
  endtask

  task automatic test_strobe_held();
    int pulses = 0;
    bit prev_in2 = 1'b0;
    settle(0, 0, 4);
    for (int k = 0; k < 62; k++) begin
      tick(1'b0, k < 50);
      if (input2 && !prev_in2) pulses++;
      prev_in2 = input2;
      n_compared++;
      if ({input1, input2, busy, glitch_count} !== m_out) begin
        n_mismatched++;
        $display("FAIL strobe_held_model k=%0d: got %h want %h", k,
                 {input1, input2, busy, glitch_count}, m_out);
      end
    end
    n_compared++;
    if (pulses !== 1) begin
      n_mismatched++;
      $display("FAIL strobe_held_pulses: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_random();
    int hold_d = 0;
    int hold_s = 0;
    bit d = 1'b0;
    bit s = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (hold_d == 0) begin
        d = 1'($urandom_range(0, 1));
        hold_d = int'($urandom_range(1, 9));
      end
      if (hold_s == 0) begin
        s = 1'($urandom_range(0, 1));
        hold_s = int'($urandom_range(1, 9));
      end
      tick(d, s);
      hold_d--;
      hold_s--;
      n_compared++;
      if ({input1, input2, busy, glitch_count} !== m_out) begin
        n_mismatched++;
        $display("FAIL random n=%0d: got in1=%b in2=%b busy=%b glitch=%0d, want %h",
                 n, input1, input2, busy, glitch_count, m_out);
      end
    end
  endtask

  task automatic test_saturation();
    settle(0, 0, 12);
    for (int r = 0; r < 300; r++) begin
      tick(1, 0); tick(1, 0);
      repeat (4) tick(0, 0);
    end
    n_compared++;
    if (glitch_count !== 8'd255 || input1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL glitch_saturate: got glitch=%0d in1=%b, want glitch=255 in1=0", glitch_count, input1);
    end
  endtask

  task automatic test_reset_mid_pulse();
    settle(1, 0, 12);
    for (int k = 1; k <= 8; k++) tick(1, 1);
    n_compared++;
    if (input2 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL pulse_before_reset: got in2=%b, want 1", input2);
    end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (input2 !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL async_reset_drop: got in2=%b busy=%b, want 0 0 before next edge", input2, busy);
    end
    raw_data = 1'b0;
    raw_strobe = 1'b0;
    @(posedge clk);
    #1;
    n_compared++;
    if (input1 !== 1'b0 || glitch_count !== 8'd0) begin
      n_mismatched++;
      $display("FAIL reset_clears: got in1=%b glitch=%0d, want 0 0", input1, glitch_count);
    end
    rst_n = 1'b1;
    model_reset();
    settle(0, 0, 5);
  endtask

  initial begin
    rst_n = 1'b0;
    raw_data = 1'b0;
    raw_strobe = 1'b0;
    model_reset();
    test_reset();
    test_clean_data();
    test_write_cycle();
    test_bounce();
    test_frozen();
    test_strobe_held();
    test_random();
    test_saturation();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
